// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and flag bundle shared by the multi-cycle ALU
package alu_pkg;
   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_SLT  = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1001;
   localparam logic [3:0] OP_MUL  = 4'b1010;
   localparam logic [3:0] OP_DIVU = 4'b1100;
   localparam logic [3:0] OP_REMU = 4'b1101;

   typedef logic [1:0] state_t;
   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_BUSY = 2'd1;
   localparam state_t S_DONE = 2'd2;

   typedef struct packed {
      logic zero;
      logic negative;
      logic carry;
      logic overflow;
      logic illegal;
   } flags_t;

   function automatic logic is_iter(input logic [3:0] op);
      return op == OP_MUL || op == OP_DIVU || op == OP_REMU;
   endfunction
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: shift-add multiplier and restoring divider, one bit per cycle for WIDTH cycles
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] result
);
   localparam int CW = $clog2(WIDTH);
   logic             busy;
   logic [CW-1:0]    cnt;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] acc, q, d, acc_n, q_n, d_n;
   logic [WIDTH:0]   shifted;
   logic             ge, is_mul;
   // acc: product (MUL) or partial remainder (DIV); q: multiplier or dividend/quotient; d: multiplicand or divisor
   always_comb begin
      is_mul  = op_q == OP_MUL;
      shifted = {acc, q[WIDTH-1]};
      ge      = shifted >= {1'b0, d};
      acc_n   = is_mul ? acc + (q[0] ? d : '0) : (ge ? shifted[WIDTH-1:0] - d : shifted[WIDTH-1:0]);
      q_n     = is_mul ? q >> 1 : {q[WIDTH-2:0], ge};
      d_n     = is_mul ? d << 1 : d;
   end
   // the final step is presented combinationally so the caller latches it on the WIDTH-th edge
   assign done   = busy && cnt == CW'(WIDTH - 1);
   assign result = op_q == OP_DIVU ? q_n : acc_n;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         cnt  <= '0;
         op_q <= '0;
         acc  <= '0;
         q    <= '0;
         d    <= '0;
      end else if (start) begin
         busy <= 1'b1;
         cnt  <= '0;
         op_q <= op;
         acc  <= '0;
         q    <= op == OP_MUL ? b : a;
         d    <= op == OP_MUL ? a : b;
      end else if (busy) begin
         busy <= !done;
         cnt  <= cnt + 1'b1;
         acc  <= acc_n;
         q    <= q_n;
         d    <= d_n;
      end
   end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake; single-cycle ops resolve at accept,
// MUL/DIVU/REMU run on the iterative engine for WIDTH cycles.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_control,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] alu_result,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow,
   output logic             illegal,
   output logic             out_valid,
   input  logic             out_ready
);
   localparam int SW = $clog2(WIDTH);
   state_t           state;
   flags_t           flg, fl_c, md_fl;
   logic             rdy_en, accept, md_done;
   logic [WIDTH-1:0] res_c, md_result;
   logic [WIDTH:0]   sum, dif;
   logic [SW-1:0]    sh;
   always_comb begin
      sh    = b[SW-1:0];
      sum   = {1'b0, a} + {1'b0, b};
      dif   = {1'b0, a} - {1'b0, b};
      res_c = '0;
      fl_c  = '0;
      case (alu_control)
         OP_AND:  res_c = a & b;
         OP_OR:   res_c = a | b;
         OP_XOR:  res_c = a ^ b;
         OP_ADD: begin
            res_c         = sum[WIDTH-1:0];
            fl_c.carry    = sum[WIDTH];
            fl_c.overflow = a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
         end
         OP_SUB: begin
            res_c         = dif[WIDTH-1:0];
            fl_c.carry    = !dif[WIDTH];
            fl_c.overflow = a[WIDTH-1] != b[WIDTH-1] && dif[WIDTH-1] != a[WIDTH-1];
         end
         OP_SLL:  res_c = a << sh;
         OP_SRL:  res_c = a >> sh;
         OP_SRA:  res_c = $signed(a) >>> sh;
         OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, a < b};
         default: fl_c.illegal = !is_iter(alu_control);
      endcase
      fl_c.zero         = res_c == '0;
      fl_c.negative     = res_c[WIDTH-1];
      md_fl             = '0;
      md_fl.zero        = md_result == '0;
      md_fl.negative    = md_result[WIDTH-1];
   end
   // rdy_en keeps in_ready low during reset and for the edge that releases it
   assign in_ready  = state == S_IDLE && rdy_en;
   assign out_valid = state == S_DONE;
   assign accept    = in_valid && in_ready;
   assign {zero, negative, carry, overflow, illegal} = flg;
   alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (accept && is_iter(alu_control)),
      .op     (alu_control),
      .a      (a),
      .b      (b),
      .done   (md_done),
      .result (md_result)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         rdy_en     <= 1'b0;
         alu_result <= '0;
         flg        <= '0;
      end else begin
         rdy_en <= 1'b1;
         case (state)
            S_IDLE: if (accept) begin
               state <= is_iter(alu_control) ? S_BUSY : S_DONE;
               if (!is_iter(alu_control)) begin
                  alu_result <= res_c;
                  flg        <= fl_c;
               end
            end
            S_BUSY: if (md_done) begin
               state      <= S_DONE;
               alu_result <= md_result;
               flg        <= md_fl;
            end
            S_DONE: if (out_ready) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors with a scoreboard queue checked by an independent output monitor
module tb_alu_mc;
   logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] a, b, alu_result;
   logic [3:0]  alu_control;
   logic        zero, negative, carry, overflow, illegal;
   int          checks = 0, errors = 0;
   logic [36:0] exp_q[$];
   alu_mc #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .alu_control(alu_control),
      .in_valid(in_valid), .in_ready(in_ready), .alu_result(alu_result),
      .zero(zero), .negative(negative), .carry(carry), .overflow(overflow),
      .illegal(illegal), .out_valid(out_valid), .out_ready(out_ready)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   // monitor: every transfer must match the oldest expected response
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
         else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            chk("result", alu_result, e[36:5]);
            chk("flags_znvci", {zero, negative, carry, overflow, illegal}, e[4:0]);
         end
      end
   end
   task automatic run(input string tag, input logic [3:0] op, input logic [31:0] ta, input logic [31:0] tb2,
                      input logic [31:0] er, input logic [4:0] ef, input int lat, input int stall);
      int n;
      logic rdy_seen;
      logic [31:0] r0;
      logic [4:0] f0;
      n = 0;
      while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
      chk({tag, ":ready_wait"}, in_ready, 1);
      exp_q.push_back({er, ef});
      a = ta; b = tb2; alu_control = op; in_valid = 1; out_ready = (stall == 0);
      @(posedge clk); #1;
      in_valid = 0; a = $urandom; b = $urandom; alu_control = 4'($urandom_range(0, 15));
      n = 1; rdy_seen = 0;
      while (!out_valid && n < 200) begin rdy_seen |= in_ready; @(posedge clk); #1; n++; end
      chk({tag, ":latency"}, n, lat);
      chk({tag, ":busy_in_ready"}, rdy_seen, 0);
      if (stall > 0) begin
         r0 = alu_result; f0 = {zero, negative, carry, overflow, illegal};
         repeat (stall) begin
            @(posedge clk); #1;
            chk({tag, ":stall_hold"}, {out_valid, in_ready, alu_result, zero, negative, carry, overflow, illegal},
                {1'b1, 1'b0, r0, f0});
         end
         out_ready = 1;
      end
      @(posedge clk); #1;
      chk({tag, ":after_xfer"}, {in_ready, out_valid}, 2'b10);
   endtask
   initial begin
      int n;
      logic seen;
      clk = 0; rst_n = 0; in_valid = 0; out_ready = 1; a = 0; b = 0; alu_control = 0;
      #7;
      chk("reset_state", {in_ready, out_valid, alu_result, zero, negative, carry, overflow, illegal}, 0);
      #5 rst_n = 1;
      @(posedge clk); #1;
      chk("ready_after_reset", in_ready, 1);
      run("add_ovf",  4'b0010, 32'h7FFFFFFF, 32'h1,        32'h80000000, 5'b01010, 1, 0);
      run("sub_eq",   4'b0100, 32'd5,        32'd5,        32'h0,        5'b10100, 1, 0);
      run("slt",      4'b1000, 32'hFFFFFFFF, 32'h1,        32'h1,        5'b00000, 1, 0);
      run("sltu",     4'b1001, 32'hFFFFFFFF, 32'h1,        32'h0,        5'b10000, 1, 0);
      run("slt_pos",  4'b1000, 32'h1,        32'hFFFFFFFF, 32'h0,        5'b10000, 1, 0);
      run("mul",      4'b1010, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 5'b01000, 33, 0);
      run("divu_0",   4'b1100, 32'd100,      32'd0,        32'hFFFFFFFF, 5'b01000, 33, 0);
      run("remu",     4'b1101, 32'd100,      32'd7,        32'd2,        5'b00000, 33, 5);
      run("illegal",  4'b1111, 32'h1234,     32'h5678,     32'h0,        5'b10001, 1, 0);
      run("sra",      4'b0111, 32'h80000000, 32'h24,       32'hF8000000, 5'b01000, 1, 0);
      run("and",      4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 5'b01000, 1, 0);
      run("or",       4'b0001, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 5'b00000, 1, 2);
      run("xor",      4'b0011, 32'hAAAA5555, 32'hFFFFFFFF, 32'h5555AAAA, 5'b00000, 1, 0);
      run("add_cy",   4'b0010, 32'hFFFFFFFF, 32'h1,        32'h0,        5'b10100, 1, 0);
      run("sub_brw",  4'b0100, 32'd3,        32'd5,        32'hFFFFFFFE, 5'b01000, 1, 0);
      run("sub_ovf",  4'b0100, 32'h80000000, 32'h1,        32'h7FFFFFFF, 5'b00110, 1, 0);
      run("sll31",    4'b0101, 32'h1,        32'h1F,       32'h80000000, 5'b01000, 1, 0);
      run("sll_wrap", 4'b0101, 32'h1,        32'h21,       32'h2,        5'b00000, 1, 0);
      run("srl",      4'b0110, 32'h80000000, 32'h4,        32'h08000000, 5'b00000, 1, 0);
      run("mul_small",4'b1010, 32'd7,        32'd6,        32'd42,       5'b00000, 33, 0);
      run("mul_wrap", 4'b1010, 32'h10000,    32'h10000,    32'h0,        5'b10000, 33, 0);
      run("divu",     4'b1100, 32'd100,      32'd7,        32'd14,       5'b00000, 33, 0);
      run("remu_0",   4'b1101, 32'd5,        32'd0,        32'd5,        5'b00000, 33, 0);
      run("ill_1011", 4'b1011, 32'hFFFF,     32'h1,        32'h0,        5'b10001, 1, 0);
      run("ill_1110", 4'b1110, 32'hFFFF,     32'h1,        32'h0,        5'b10001, 1, 0);
      // abort a DIVU mid-flight: nothing may ever be presented for it
      n = 0;
      while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
      a = 32'd100; b = 32'd3; alu_control = 4'b1100; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      repeat (9) @(posedge clk);
      #1;
      chk("abort_busy", {in_ready, out_valid}, 2'b00);
      rst_n = 0;
      #1;
      chk("abort_async", {in_ready, out_valid, alu_result, zero, negative, carry, overflow, illegal}, 0);
      @(posedge clk); #2;
      chk("abort_hold", {in_ready, out_valid}, 2'b00);
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
      chk("abort_ready", {in_ready, out_valid}, 2'b10);
      seen = 0;
      repeat (40) begin @(posedge clk); #1; seen |= out_valid; end
      chk("abort_no_output", seen, 0);
      run("post_abort", 4'b0010, 32'd2, 32'd3, 32'd5, 5'b00000, 1, 0);
      repeat (2) @(posedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
